// File: rtl/signed_sum_accumulator.sv
// signed_sum_accumulator
// Collects frames of COUNT signed sums with saturating accumulation and
// presents each frame total plus a sticky overflow flag on a valid/ready port.
module signed_sum_accumulator #(
  parameter int WIDTH = 32,
  parameter int COUNT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_ovf,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int CW = (COUNT > 1) ? $clog2(COUNT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(COUNT - 1);
  localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_acc;
  logic [CW-1:0]    r_cnt;
  logic             r_ovf;

  state_t           w_state_next;
  logic [WIDTH-1:0] w_acc_next;
  logic [CW-1:0]    w_cnt_next;
  logic             w_ovf_next;

  logic             w_in_xfer;
  logic             w_out_xfer;
  logic [WIDTH:0]   w_sum;
  logic             w_pos_ovf;
  logic             w_neg_ovf;
  logic [WIDTH-1:0] w_sat_sum;

  // Handshake decode; ready/valid come from state only.
  assign in_ready   = (r_state == ACCUM);
  assign out_valid  = (r_state == HOLD);
  assign out_data   = r_acc;
  assign out_ovf    = r_ovf;
  assign w_in_xfer  = in_valid & in_ready;
  assign w_out_xfer = out_valid & out_ready;

  // Sign-extended WIDTH+1 sum: the top two bits disagree exactly when the
  // WIDTH-bit result overflowed; bit WIDTH gives the true sign.
  assign w_sum     = {r_acc[WIDTH-1], r_acc} + {in_data[WIDTH-1], in_data};
  assign w_pos_ovf = ~w_sum[WIDTH] &  w_sum[WIDTH-1];
  assign w_neg_ovf =  w_sum[WIDTH] & ~w_sum[WIDTH-1];

  // Clamp to the representable range on overflow.
  always_comb begin
    w_sat_sum = w_sum[WIDTH-1:0];
    if (w_pos_ovf) begin
      w_sat_sum = SAT_MAX;
    end else if (w_neg_ovf) begin
      w_sat_sum = SAT_MIN;
    end
  end

  // Next-state and datapath update; clear overrides any transfer.
  always_comb begin
    w_state_next = r_state;
    w_acc_next   = r_acc;
    w_cnt_next   = r_cnt;
    w_ovf_next   = r_ovf;
    if (clear) begin
      w_state_next = ACCUM;
      w_acc_next   = '0;
      w_cnt_next   = '0;
      w_ovf_next   = 1'b0;
    end else begin
      case (r_state)
        ACCUM: begin
          if (w_in_xfer) begin
            w_acc_next = w_sat_sum;
            w_ovf_next = r_ovf | w_pos_ovf | w_neg_ovf;
            if (r_cnt == CNT_LAST) begin
              w_cnt_next   = '0;
              w_state_next = HOLD;
            end else begin
              w_cnt_next = r_cnt + 1'b1;
            end
          end
        end
        HOLD: begin
          if (w_out_xfer) begin
            w_acc_next   = '0;
            w_ovf_next   = 1'b0;
            w_state_next = ACCUM;
          end
        end
        default: begin
          w_state_next = ACCUM;
        end
      endcase
    end
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ACCUM;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_acc   <= w_acc_next;
      r_cnt   <= w_cnt_next;
      r_ovf   <= w_ovf_next;
    end
  end

endmodule

// File: tb/tb_signed_sum_accumulator.sv
// Directed testbench for signed_sum_accumulator (WIDTH=32, COUNT=4).
module tb_signed_sum_accumulator;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] out_data;
  logic        out_ovf;
  logic        out_valid;
  logic        out_ready = 1'b1;

  int n_vec = 0;
  int n_err = 0;

  signed_sum_accumulator #(.WIDTH(32), .COUNT(4)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_ovf(out_ovf),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  // Present one input for one cycle; sample point is 1ns after the edge.
  task automatic push(input logic [31:0] v);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = v;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    $display("push in_data=%0d -> out_data=%0d ovf=%0b valid=%0b", $signed(v), $signed(out_data), out_ovf, out_valid);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_vec++; if (out_data !== 32'd0) begin $display("FAIL reset_data got %h want 0", out_data); n_err++; end
    n_vec++; if (out_ovf !== 1'b0) begin $display("FAIL reset_ovf got %b want 0", out_ovf); n_err++; end
    n_vec++; if (out_valid !== 1'b0) begin $display("FAIL reset_valid got %b want 0", out_valid); n_err++; end
    n_vec++; if (in_ready !== 1'b1) begin $display("FAIL reset_ready got %b want 1", in_ready); n_err++; end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    push(32'd13);
    n_vec++; if (out_data !== 32'd13) begin $display("FAIL basic_partial got %0d want 13", $signed(out_data)); n_err++; end
    push(-32'sd8);
    push(-32'sd5);
    n_vec++; if (out_valid !== 1'b0) begin $display("FAIL basic_early_valid got %b want 0", out_valid); n_err++; end
    push(32'd6);
    n_vec++; if (out_valid !== 1'b1) begin $display("FAIL basic_valid got %b want 1", out_valid); n_err++; end
    n_vec++; if (out_data !== 32'd6) begin $display("FAIL basic_data got %0d want 6", $signed(out_data)); n_err++; end
    n_vec++; if (out_ovf !== 1'b0) begin $display("FAIL basic_ovf got %b want 0", out_ovf); n_err++; end
    n_vec++; if (in_ready !== 1'b0) begin $display("FAIL basic_hold_ready got %b want 0", in_ready); n_err++; end
    step();
    n_vec++; if (out_valid !== 1'b0) begin $display("FAIL basic_after_valid got %b want 0", out_valid); n_err++; end
    n_vec++; if (out_data !== 32'd0) begin $display("FAIL basic_after_data got %0d want 0", $signed(out_data)); n_err++; end
    n_vec++; if (in_ready !== 1'b1) begin $display("FAIL basic_after_ready got %b want 1", in_ready); n_err++; end
  endtask

  task automatic test_pos_sat();
    push(32'h7FFF_FFF0);
    push(32'h0000_0020);
    n_vec++; if (out_data !== 32'h7FFF_FFFF) begin $display("FAIL possat_clamp got %h want 7fffffff", out_data); n_err++; end
    n_vec++; if (out_ovf !== 1'b1) begin $display("FAIL possat_flag got %b want 1", out_ovf); n_err++; end
    push(32'hFFFF_FFFF);
    n_vec++; if (out_data !== 32'h7FFF_FFFE) begin $display("FAIL possat_after got %h want 7ffffffe", out_data); n_err++; end
    push(32'd0);
    n_vec++; if (out_data !== 32'h7FFF_FFFE || out_valid !== 1'b1) begin $display("FAIL possat_final got %h/%b want 7ffffffe/1", out_data, out_valid); n_err++; end
    n_vec++; if (out_ovf !== 1'b1) begin $display("FAIL possat_sticky got %b want 1", out_ovf); n_err++; end
    step();
    n_vec++; if (out_ovf !== 1'b0) begin $display("FAIL possat_ovf_clear got %b want 0", out_ovf); n_err++; end
  endtask

  task automatic test_neg_sat();
    push(32'h8000_0010);
    push(-32'sd32);
    n_vec++; if (out_data !== 32'h8000_0000) begin $display("FAIL negsat_clamp got %h want 80000000", out_data); n_err++; end
    push(32'd0);
    push(32'd0);
    n_vec++; if (out_data !== 32'h8000_0000 || out_valid !== 1'b1) begin $display("FAIL negsat_final got %h/%b want 80000000/1", out_data, out_valid); n_err++; end
    n_vec++; if (out_ovf !== 1'b1) begin $display("FAIL negsat_flag got %b want 1", out_ovf); n_err++; end
    step();
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    push(32'd1);
    push(32'd2);
    push(32'd3);
    push(32'd4);
    n_vec++; if (out_valid !== 1'b1 || out_data !== 32'd10) begin $display("FAIL bp_frame got %0d/%b want 10/1", $signed(out_data), out_valid); n_err++; end
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 32'd99;
    for (int i = 0; i < 3; i++) begin
      step();
      $display("stall cycle %0d out_data=%0d valid=%0b ready=%0b", i, $signed(out_data), out_valid, in_ready);
      n_vec++; if (out_data !== 32'd10 || out_valid !== 1'b1 || in_ready !== 1'b0) begin $display("FAIL bp_hold%0d got %0d/%b/%b want 10/1/0", i, $signed(out_data), out_valid, in_ready); n_err++; end
    end
    @(negedge clk);
    out_ready = 1'b1;
    step();
    n_vec++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 32'd0) begin $display("FAIL bp_release got %0d/%b/%b want 0/0/1", $signed(out_data), out_valid, in_ready); n_err++; end
    step();
    in_valid = 1'b0;
    n_vec++; if (out_data !== 32'd99) begin $display("FAIL bp_first99 got %0d want 99", $signed(out_data)); n_err++; end
    push(32'd0);
    push(32'd0);
    push(32'd0);
    n_vec++; if (out_data !== 32'd99 || out_valid !== 1'b1) begin $display("FAIL bp_frame2 got %0d/%b want 99/1", $signed(out_data), out_valid); n_err++; end
    step();
  endtask

  task automatic test_clear();
    push(32'd5);
    push(32'd7);
    @(negedge clk);
    clear    = 1'b1;
    in_valid = 1'b1;
    in_data  = 32'd100;
    step();
    clear    = 1'b0;
    in_valid = 1'b0;
    n_vec++; if (out_data !== 32'd0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin $display("FAIL clr_state got %0d/%b/%b want 0/1/0", $signed(out_data), in_ready, out_valid); n_err++; end
    push(32'd1);
    push(32'd1);
    push(32'd1);
    n_vec++; if (out_valid !== 1'b0) begin $display("FAIL clr_cnt_reset got %b want 0", out_valid); n_err++; end
    push(32'd1);
    n_vec++; if (out_data !== 32'd4 || out_valid !== 1'b1) begin $display("FAIL clr_frame got %0d/%b want 4/1", $signed(out_data), out_valid); n_err++; end
    step();
    // clear while a finished frame is being held off
    out_ready = 1'b0;
    push(32'd2);
    push(32'd2);
    push(32'd2);
    push(32'd2);
    @(negedge clk);
    clear = 1'b1;
    step();
    clear = 1'b0;
    out_ready = 1'b1;
    n_vec++; if (out_valid !== 1'b0 || out_data !== 32'd0 || in_ready !== 1'b1) begin $display("FAIL clr_hold got %0d/%b/%b want 0/0/1", $signed(out_data), out_valid, in_ready); n_err++; end
  endtask

  task automatic test_async_reset();
    push(32'd7);
    push(32'd8);
    n_vec++; if (out_data !== 32'd15) begin $display("FAIL ar_pre got %0d want 15", $signed(out_data)); n_err++; end
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    n_vec++; if (out_data !== 32'd0 || out_ovf !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin $display("FAIL ar_immediate got %0d/%b/%b/%b want 0/0/0/1", $signed(out_data), out_ovf, out_valid, in_ready); n_err++; end
    #1;
    rst_n = 1'b1;
    push(32'd10);
    push(32'd3);
    push(-32'sd5);
    n_vec++; if (out_valid !== 1'b0) begin $display("FAIL ar_cnt got %b want 0", out_valid); n_err++; end
    push(-32'sd3);
    n_vec++; if (out_data !== 32'd5 || out_valid !== 1'b1) begin $display("FAIL ar_frame got %0d/%b want 5/1", $signed(out_data), out_valid); n_err++; end
    step();
  endtask

  initial begin
    fork
      begin
        #200000;
        $display("FAIL timeout got running want finished");
        $fatal(1, "timeout");
      end
    join_none
    test_reset();
    test_basic();
    test_pos_sat();
    test_neg_sat();
    test_back_to_back();
    test_clear();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/signed_sum_accumulator.md
# signed_sum_accumulator

Downstream consumer of the 32-bit signed two's-complement adder. Accepts a stream of signed sums over a valid/ready handshake, accumulates a frame of `COUNT` sums with saturating arithmetic, then presents the frame total and a sticky overflow flag on a valid/ready output port. Lets the adder run continuously while frame totals are collected at the next level.

## Interface

Parameters:
- `WIDTH`, 32: data width of input and accumulator, two's complement.
- `COUNT`, 4: sums per frame; legal range 1..65535.

Ports:
- `clk`: input, 1 bit. Single clock; all state updates on the rising edge.
- `rst_n`: input, 1 bit. Asynchronous, active-low reset.
- `clear`: input, 1 bit. Synchronous frame abort.
- `in_data`: input, `WIDTH` bits. Signed sum from the adder.
- `in_valid`: input, 1 bit. `in_data` is valid.
- `in_ready`: output, 1 bit. Block can accept `in_data`.
- `out_data`: output, `WIDTH` bits. Accumulator value, signed.
- `out_ovf`: output, 1 bit. Sticky saturation flag for the current frame.
- `out_valid`: output, 1 bit. Frame total is available.
- `out_ready`: input, 1 bit. Consumer accepts the frame total.

## Operation

- State machine with two states, `ACCUM` and `HOLD`. Reset state is `ACCUM`.
- Registers:
  - `acc`: `WIDTH` bits.
  - `cnt`: `max(1,$clog2(COUNT))` bits.
  - `ovf`: 1 bit.
  - `state`.
- Output mapping: `out_data` = `acc`; `out_ovf` = `ovf`; `in_ready` = (state==`ACCUM`); `out_valid` = (state==`HOLD`).
- An input transfer occurs when `in_valid && in_ready`. An output transfer occurs when `out_valid && out_ready`.
- ACCUM, on input transfer:
  - `acc` <= sat(`acc` + `in_data`).
  - `ovf` <= `ovf` | sat_hit.
  - If `cnt`==`COUNT`-1: `cnt` <= 0 and go to `HOLD`.
  - Otherwise: `cnt` <= `cnt`+1.
- ACCUM, no input transfer: all state holds.
- HOLD, on output transfer: `acc` <= 0, `ovf` <= 0, go to `ACCUM`.
- HOLD, no output transfer: all state holds. `in_ready`=0, so upstream is back-pressured.
- Arithmetic:
  - Form the sum at `WIDTH`+1 bits with both operands sign-extended.
  - Positive overflow occurs when both operands are ≥0 and the `WIDTH`-bit result is negative. The result is forced to 0x7FFFFFFF (max positive).
  - Negative overflow occurs when both operands are negative and the result is ≥0. The result is forced to 0x80000000 (min negative).
  - sat_hit=1 in either overflow case.
  - Later additions operate on the saturated value; there is no wrap-around.
- `clear`:
  - Highest priority after reset, taking effect in any state.
  - Next cycle: `acc`=0, `cnt`=0, `ovf`=0, state=`ACCUM`.
  - An input or output transfer in the same cycle is discarded; the data is not accumulated and the frame is not counted as delivered.
- `COUNT`=1: every accepted input immediately completes a frame.

## Timing

- Reset (`rst_n`=0, asynchronous):
  - `acc`=0, `cnt`=0, `ovf`=0, state=`ACCUM`.
  - Outputs: `out_data`=0, `out_ovf`=0, `out_valid`=0, `in_ready`=1.
  - No transfers are taken while `rst_n`=0.
- Reset mid-frame discards the partial frame. The first input after `rst_n` deasserts starts a new frame.
- `out_data` and `out_ovf` reflect a transfer one cycle after the accepting edge.
- `out_valid` rises on the edge that accepts input number `COUNT`.
- Input-to-output latency: 1 cycle after the last input transfer.
- `out_data` and `out_ovf` are stable while `out_valid`=1 and `out_ready`=0.
- Minimum frame period: `COUNT`+1 cycles (`COUNT` input cycles plus at least one `HOLD` cycle). `in_ready` returns to 1 on the cycle after the output transfer.
- No combinational path from inputs to outputs. `in_ready` and `out_valid` depend on state only.

## Test plan

1. Basic frame, `COUNT`=4.
   - Stimulus: inputs 13, -8, -5, 6, each accepted with `out_ready`=1.
   - Response: `out_valid`=1 in the cycle after the 4th transfer, `out_data`=6, `out_ovf`=0. Next cycle `out_valid`=0 and `out_data`=0.
2. Positive saturation.
   - Stimulus: inputs 0x7FFFFFF0, 0x00000020, -1, 0.
   - Response: `acc` is 0x7FFFFFFF after the 2nd input. Final `out_data`=0x7FFFFFFE, `out_ovf`=1. `out_ovf` clears after the output transfer.
3. Negative saturation.
   - Stimulus: inputs 0x80000010, -32, 0, 0.
   - Response: `out_data`=0x80000000, `out_ovf`=1.
4. Back-pressure.
   - Stimulus: frame of 1, 2, 3, 4 with `out_ready`=0 for 3 cycles after `out_valid` rises, and `in_valid` held high with value 99.
   - Response: `out_data`=10 held and `in_ready`=0 for those cycles; 99 is not accumulated. After `out_ready`=1, the next frame starts with 99 as its first input.
5. `clear` mid-frame.
   - Stimulus: inputs 5, 7, then `clear`=1 together with `in_valid`=1 carrying 100.
   - Response: next cycle `out_data`=0 and `cnt`=0; 100 is discarded. Inputs 1, 1, 1, 1 then yield `out_data`=4.
6. Async reset mid-frame.
   - Stimulus: pulse `rst_n` low between clock edges after 2 inputs.
   - Response: all outputs at reset values immediately, without waiting for a clock edge. Next frame 10, 3, -5, -3 yields 5, with `COUNT` counted from the new frame.
